// File: rtl/bit_diff_sched.sv
// Round-robin scheduler sharing one iterative bit-difference engine among NUM_REQ requesters.
// Each job is granted, issued to the engine, then its tagged result is held on a valid/ready port.
module bit_diff_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 256,
  localparam int unsigned RES_W     = $clog2(2 * DATA_WIDTH + 1),
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                eng_go,
  output logic [DATA_WIDTH-1:0]               eng_data,
  input  logic                                eng_done,
  input  logic [RES_W-1:0]                    eng_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RES_W-1:0]                    out_result,
  output logic [ID_W-1:0]                     out_id,
  output logic [31:0]                         job_count,
  output logic                                timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [ID_W-1:0]         cur_id_q;
  logic [DATA_WIDTH-1:0]   eng_data_q;
  logic [CntW-1:0]         wait_cnt_q;
  logic                    out_valid_q;
  logic [RES_W-1:0]        out_result_q;
  logic [ID_W-1:0]         out_id_q;
  logic [31:0]             job_count_q;
  logic                    timeout_err_q;

  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_idx;
  logic                    grant;
  logic                    done_hit;
  logic                    to_hit;
  logic                    accept;

  // Search rr_ptr+1, rr_ptr+2, ... ; walking the offsets downward lets the nearest one win.
  always_comb begin
    int unsigned     cand;
    logic [ID_W-1:0] cand_id;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      cand    = (32'(rr_ptr_q) + off) % NUM_REQ;
      cand_id = ID_W'(cand);
      if (req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
  end

  assign grant     = (state_q == StIdle) && !out_valid_q && gnt_found;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d  = state_q;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: state_d = StArm;
      // Bubble so the engine can drop the done level left over from the previous job.
      StArm:   state_d = StWait;
      StWait: begin
        if (eng_done) begin
          done_hit = 1'b1;
          state_d  = StHold;
        end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (out_valid_q && out_ready) begin
          accept  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      eng_data_q    <= '0;
      wait_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_id_q      <= '0;
      job_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        eng_data_q <= req_data[gnt_idx];
        cur_id_q   <= gnt_idx;
        rr_ptr_q   <= gnt_idx;
      end
      if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end else begin
        wait_cnt_q <= '0;
      end
      if (done_hit) begin
        out_valid_q  <= 1'b1;
        out_result_q <= eng_result;
        out_id_q     <= cur_id_q;
        job_count_q  <= job_count_q + 32'd1;
      end
      if (accept) begin
        out_valid_q <= 1'b0;
      end
      if (to_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign eng_go      = (state_q == StIssue);
  assign eng_data    = eng_data_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_id      = out_id_q;
  assign job_count   = job_count_q;
  assign timeout_err = timeout_err_q;

endmodule
